osu_cnt_scan: RTL and testbench

- Parametrised synchronous up/down counter macro cell with parallel load, scan chain, and wrap or saturate mode.
- Successor to the single-function combinational primitives in the OSU350 model set; first sequential macro in the library.
- Characterized and used as a drop-in counter/timer cell; the scan path makes it DFT-compatible with the library's scan flops.

---
 rtl/osu_cnt_scan.sv | 86 ++++++++
 tb/tb_osu_cnt_scan.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osu_cnt_scan.sv
// osu_cnt_scan: up/down counter macro cell with
// parallel load, MSB-out scan chain and wrap/saturate.
module osu_cnt_scan #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = (2**WIDTH) - 1,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             SE,
  input  logic             SI,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             UP,
  input  logic             SAT,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             OVF,
  output logic             SO
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] scan_v;
  logic             at_top;
  logic             at_zero;

  assign at_top  = (q_q >= MAXV);
  assign at_zero = (q_q == '0);

  if (WIDTH == 1) begin : g_w1
    assign scan_v = SI;
  end else begin : g_wn
    assign scan_v = {q_q[WIDTH-2:0], SI};
  end

  // Next count and event flag; scan beats load beats count.
  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    priority case (1'b1)
      SE: q_d = scan_v;
      LD: q_d = (D > MAXV) ? MAXV : D;
      EN: begin
        if (UP) begin
          if (at_top) begin
            q_d   = SAT ? MAXV : '0;
            ovf_d = 1'b1;
          end else begin
            q_d = q_q + ONE;
          end
        end else begin
          if (at_zero) begin
            q_d   = SAT ? '0 : MAXV;
            ovf_d = 1'b1;
          end else begin
            q_d = q_q - ONE;
          end
        end
      end
      default: q_d = q_q;
    endcase
  end

  // State register with synchronous reset taking priority.
  always_ff @(posedge CLK) begin
    if (R) begin
      q_q   <= RSTV;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign TC  = EN & ~SE & ~LD & ~R & (UP ? at_top : at_zero);
  assign Q   = q_q;
  assign OVF = ovf_q;
  assign SO  = q_q[WIDTH-1];

endmodule

// File: tb/tb_osu_cnt_scan.sv
// tb_osu_cnt_scan: scoreboard bench for osu_cnt_scan
// (WIDTH=4/MAX=9 instance and WIDTH=1/MAX=1 instance).
module tb_osu_cnt_scan;

  logic       clk = 1'b0;
  logic       r, se, si, ld, en, up, sat;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc, ovf, so;

  logic       br, bse, bsi, bld, ben, bup, bsat;
  logic [0:0] bd;
  logic [0:0] bq;
  logic       btc, bovf, bso;

  int checks = 0;
  int errors = 0;

  logic [3:0] eq[$];
  logic       eo[$];
  logic [3:0] pq;
  logic       po;

  always #5 clk = ~clk;

  osu_cnt_scan #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) u_a (
    .CLK(clk), .R(r), .SE(se), .SI(si), .LD(ld), .D(d),
    .EN(en), .UP(up), .SAT(sat),
    .Q(q), .TC(tc), .OVF(ovf), .SO(so)
  );

  osu_cnt_scan #(.WIDTH(1), .MAX_VAL(1), .RST_VAL(0)) u_b (
    .CLK(clk), .R(br), .SE(bse), .SI(bsi), .LD(bld), .D(bd),
    .EN(ben), .UP(bup), .SAT(bsat),
    .Q(bq), .TC(btc), .OVF(bovf), .SO(bso)
  );

  task automatic drv(input logic r_i, se_i, si_i, ld_i,
                     input logic [3:0] d_i,
                     input logic en_i, up_i, sat_i);
    r = r_i; se = se_i; si = si_i; ld = ld_i;
    d = d_i; en = en_i; up = up_i; sat = sat_i;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drv(1, 0, 0, 0, 4'd0, 0, 0, 0);
    checks++;
    if (tc !== 1'b0) begin
      errors++; $display("FAIL reset_tc got %b want 0", tc);
    end
    eq.push_back(4'd0); eo.push_back(1'b0);
    tick();
    pq = eq.pop_front(); po = eo.pop_front();
    checks++;
    if (q !== pq) begin
      errors++; $display("FAIL reset_q got %0d want %0d", q, pq);
    end
    checks++;
    if (ovf !== po) begin
      errors++; $display("FAIL reset_ovf got %b want %b", ovf, po);
    end
    checks++;
    if (so !== 1'b0) begin
      errors++; $display("FAIL reset_so got %b want 0", so);
    end
  endtask

  task automatic test_upcount();
    int seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int prev = 0;
    drv(0, 0, 0, 0, 4'd0, 1, 1, 0);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (tc !== (prev == 9)) begin
        errors++;
        $display("FAIL up_tc[%0d] got %b want %b", i, tc, prev == 9);
      end
      eq.push_back(4'(seq[i]));
      eo.push_back(prev == 9);
      tick();
      pq = eq.pop_front(); po = eo.pop_front();
      checks++;
      if (q !== pq) begin
        errors++; $display("FAIL up_q[%0d] got %0d want %0d", i, q, pq);
      end
      checks++;
      if (ovf !== po) begin
        errors++; $display("FAIL up_ovf[%0d] got %b want %b", i, ovf, po);
      end
      prev = seq[i];
    end
  endtask

  task automatic test_down_sat();
    int seq[4] = '{1, 0, 0, 0};
    logic ov[4] = '{0, 0, 1, 1};
    logic tx[4] = '{0, 0, 1, 1};
    drv(0, 0, 0, 1, 4'd2, 0, 0, 1);
    eq.push_back(4'd2); eo.push_back(1'b0);
    tick();
    pq = eq.pop_front(); po = eo.pop_front();
    checks++;
    if (q !== pq) begin
      errors++; $display("FAIL dsat_load got %0d want %0d", q, pq);
    end
    drv(0, 0, 0, 0, 4'd0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tc !== tx[i]) begin
        errors++; $display("FAIL dsat_tc[%0d] got %b want %b", i, tc, tx[i]);
      end
      eq.push_back(4'(seq[i])); eo.push_back(ov[i]);
      tick();
      pq = eq.pop_front(); po = eo.pop_front();
      checks++;
      if (q !== pq) begin
        errors++; $display("FAIL dsat_q[%0d] got %0d want %0d", i, q, pq);
      end
      checks++;
      if (ovf !== po) begin
        errors++; $display("FAIL dsat_ovf[%0d] got %b want %b", i, ovf, po);
      end
    end
  endtask

  task automatic test_up_sat();
    drv(0, 0, 0, 1, 4'd8, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 4'd0, 1, 1, 1);
    eq.push_back(4'd9); eo.push_back(1'b0);
    eq.push_back(4'd9); eo.push_back(1'b1);
    eq.push_back(4'd9); eo.push_back(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      pq = eq.pop_front(); po = eo.pop_front();
      checks++;
      if (q !== pq || ovf !== po) begin
        errors++;
        $display("FAIL usat[%0d] got q=%0d ovf=%b want q=%0d ovf=%b",
                 i, q, ovf, pq, po);
      end
    end
  endtask

  task automatic test_load_priority();
    drv(0, 0, 0, 1, 4'd0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 1, 4'd15, 1, 1, 0);
    checks++;
    if (tc !== 1'b0) begin
      errors++; $display("FAIL ldpri_tc got %b want 0", tc);
    end
    eq.push_back(4'd9); eo.push_back(1'b0);
    tick();
    pq = eq.pop_front(); po = eo.pop_front();
    checks++;
    if (q !== pq || ovf !== po) begin
      errors++;
      $display("FAIL ld_clamp got q=%0d ovf=%b want q=%0d ovf=%b",
               q, ovf, pq, po);
    end
    drv(0, 1, 1, 1, 4'd5, 1, 1, 0);
    eq.push_back(4'd3); eo.push_back(1'b0);
    tick();
    pq = eq.pop_front(); po = eo.pop_front();
    checks++;
    if (q !== pq || ovf !== po) begin
      errors++;
      $display("FAIL se_over_ld got q=%0d ovf=%b want q=%0d ovf=%b",
               q, ovf, pq, po);
    end
  endtask

  task automatic test_scan();
    logic       sin[4] = '{1, 0, 1, 1};
    logic [3:0] qs[4]  = '{4'd1, 4'd2, 4'd5, 4'd11};
    logic       sos[4] = '{0, 0, 0, 1};
    drv(0, 0, 0, 1, 4'd0, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, sin[i], 0, 4'd0, 0, 0, 0);
      eq.push_back(qs[i]); eo.push_back(1'b0);
      tick();
      pq = eq.pop_front(); po = eo.pop_front();
      checks++;
      if (q !== pq || ovf !== po) begin
        errors++;
        $display("FAIL scan_q[%0d] got q=%0d ovf=%b want q=%0d ovf=%b",
                 i, q, ovf, pq, po);
      end
      checks++;
      if (so !== sos[i]) begin
        errors++; $display("FAIL scan_so[%0d] got %b want %b", i, so, sos[i]);
      end
    end
    drv(0, 0, 0, 0, 4'd0, 1, 1, 0);
    checks++;
    if (tc !== 1'b1) begin
      errors++; $display("FAIL scan_tc got %b want 1", tc);
    end
    eq.push_back(4'd0); eo.push_back(1'b1);
    tick();
    pq = eq.pop_front(); po = eo.pop_front();
    checks++;
    if (q !== pq || ovf !== po) begin
      errors++;
      $display("FAIL scan_wrap got q=%0d ovf=%b want q=%0d ovf=%b",
               q, ovf, pq, po);
    end
    drv(0, 0, 0, 0, 4'd0, 0, 0, 0);
    eq.push_back(4'd0); eo.push_back(1'b0);
    tick();
    pq = eq.pop_front(); po = eo.pop_front();
    checks++;
    if (q !== pq || ovf !== po) begin
      errors++;
      $display("FAIL idle got q=%0d ovf=%b want q=%0d ovf=%b",
               q, ovf, pq, po);
    end
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 1, 0, 4'd0, 0, 0, 0);
      tick();
    end
    drv(0, 0, 0, 0, 4'd0, 1, 0, 0);
    eq.push_back(4'd14); eo.push_back(1'b0);
    tick();
    pq = eq.pop_front(); po = eo.pop_front();
    checks++;
    if (q !== pq || ovf !== po) begin
      errors++;
      $display("FAIL scan_dec got q=%0d ovf=%b want q=%0d ovf=%b",
               q, ovf, pq, po);
    end
  endtask

  task automatic test_reset_mid();
    drv(0, 0, 0, 1, 4'd4, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 4'd0, 1, 1, 0);
    eq.push_back(4'd5); eo.push_back(1'b0);
    tick();
    pq = eq.pop_front(); po = eo.pop_front();
    checks++;
    if (q !== pq) begin
      errors++; $display("FAIL rmid_pre got %0d want %0d", q, pq);
    end
    drv(1, 1, 1, 1, 4'd7, 1, 1, 0);
    checks++;
    if (tc !== 1'b0) begin
      errors++; $display("FAIL rmid_tc got %b want 0", tc);
    end
    eq.push_back(4'd0); eo.push_back(1'b0);
    tick();
    pq = eq.pop_front(); po = eo.pop_front();
    checks++;
    if (q !== pq || ovf !== po) begin
      errors++;
      $display("FAIL rmid got q=%0d ovf=%b want q=%0d ovf=%b",
               q, ovf, pq, po);
    end
  endtask

  task automatic test_width1();
    logic bqs[3] = '{1, 0, 1};
    logic bov[3] = '{1, 0, 1};
    logic btx[3] = '{1, 0, 1};
    br = 1; bse = 0; bsi = 0; bld = 0; bd = '0;
    ben = 0; bup = 0; bsat = 0;
    tick();
    checks++;
    if (bq !== 1'b0 || bovf !== 1'b0) begin
      errors++; $display("FAIL w1_reset got q=%b ovf=%b want 0 0", bq, bovf);
    end
    br = 0; ben = 1; bup = 0; bsat = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (btc !== btx[i]) begin
        errors++; $display("FAIL w1_tc[%0d] got %b want %b", i, btc, btx[i]);
      end
      eq.push_back(4'(bqs[i])); eo.push_back(bov[i]);
      tick();
      pq = eq.pop_front(); po = eo.pop_front();
      checks++;
      if (4'(bq) !== pq || bovf !== po || bso !== pq[0]) begin
        errors++;
        $display("FAIL w1[%0d] got q=%b ovf=%b so=%b want q=%0d ovf=%b",
                 i, bq, bovf, bso, pq, po);
      end
    end
    ben = 0;
    bse = 1; bsi = 0;
    tick();
    checks++;
    if (bq !== 1'b0 || bso !== 1'b0) begin
      errors++; $display("FAIL w1_scan got q=%b so=%b want 0 0", bq, bso);
    end
    bse = 0;
  endtask

  initial begin
    br = 1; bse = 0; bsi = 0; bld = 0; bd = '0;
    ben = 0; bup = 0; bsat = 0;
    @(negedge clk);
    test_reset();
    test_upcount();
    test_down_sat();
    test_up_sat();
    test_load_priority();
    test_scan();
    test_reset_mid();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
